// File: rtl/coax_tx_buffer.sv
// coax_tx_buffer: frame-assembly FIFO in front of the coax transmitter.
// Host words are queued, then on start they are fed one at a time into the
// transmitter's edge-triggered load/data/full interface so that consecutive
// words chain into a single frame. busy stays high until the line goes idle.
module coax_tx_buffer #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [9:0]               wr_data,
   output logic                     fifo_full,
   output logic                     fifo_empty,
   output logic [$clog2(DEPTH):0]   fifo_count,
   input  logic                     start,
   output logic                     busy,
   output logic                     overflow,
   input  logic                     clear_overflow,
   output logic                     tx_load,
   output logic [9:0]               tx_data,
   input  logic                     tx_full,
   input  logic                     tx_active
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      HOLD,
      DRAIN
   } state_t;

   state_t          state_q;
   logic [9:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            tx_load_q;
   logic [9:0]      tx_data_q;
   logic            busy_q;
   logic            seen_active_q;
   logic            push;
   logic            pop;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(DEPTH));
   assign fifo_count = count_q;
   assign overflow   = ovf_q;
   assign tx_load    = tx_load_q;
   assign tx_data    = tx_data_q;
   assign busy       = busy_q;

   assign push = wr_en && !fifo_full;
   // A pop always coincides with entry to LOAD, from IDLE on start or from HOLD
   // once the transmitter's holding register is free.
   assign pop  = !fifo_empty &&
                 (((state_q == IDLE) && start) || ((state_q == HOLD) && !tx_full));

   // Next-state for FIFO pointers, occupancy and the sticky overflow flag
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // A new overflow event wins over a simultaneous clear
      if (wr_en && fifo_full)  ovf_d = 1'b1;
      else if (clear_overflow) ovf_d = 1'b0;
   end

   // FIFO bookkeeping registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Word storage; contents need no reset since occupancy gates every read
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   // Transmit sequencer with registered load/data/busy outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         tx_load_q     <= 1'b0;
         tx_data_q     <= '0;
         busy_q        <= 1'b0;
         seen_active_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  state_q   <= LOAD;
                  tx_load_q <= 1'b1;
                  tx_data_q <= mem_q[rd_ptr_q];
                  busy_q    <= 1'b1;
               end
            end
            LOAD: begin
               tx_load_q <= 1'b0;
               state_q   <= SETTLE;
            end
            SETTLE: begin
               state_q <= HOLD;
            end
            HOLD: begin
               if (pop) begin
                  state_q   <= LOAD;
                  tx_load_q <= 1'b1;
                  tx_data_q <= mem_q[rd_ptr_q];
               end else if (fifo_empty) begin
                  state_q       <= DRAIN;
                  seen_active_q <= 1'b0;
               end
            end
            DRAIN: begin
               if (seen_active_q && !tx_active) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (tx_active) begin
                  seen_active_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               tx_load_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/coax_tx_buffer.md
Name: coax_tx_buffer

Overview:
- Frame-assembly FIFO sitting directly upstream of the coax transmitter.
- Host writes 10-bit words, then strobes start.
- Block drains the FIFO into the transmitter's edge-triggered load/data/full interface with correct pulse spacing, so consecutive words chain into one frame with no gaps.
- Reports busy until the transmitter's active output falls.

Parameters:
- DEPTH, 16, FIFO depth in words; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe; one word per cycle
- wr_data  in  10  word to enqueue
- fifo_full  out  1  FIFO holds DEPTH words
- fifo_empty  out  1  FIFO holds 0 words
- fifo_count  out  $clog2(DEPTH)+1  words held
- start  in  1  begin transmitting FIFO contents (level sampled each cycle)
- busy  out  1  frame in progress
- overflow  out  1  sticky: write attempted while fifo_full
- clear_overflow  in  1  clears overflow
- tx_load  out  1  to transmitter load (rising-edge sensitive)
- tx_data  out  10  to transmitter data
- tx_full  in  1  transmitter holding register occupied
- tx_active  in  1  transmitter driving the line

Behaviour:
- Reset (async, any state):
  - FIFO pointers and count zeroed; fifo_empty=1, fifo_full=0.
  - FSM to IDLE; busy=0, tx_load=0, tx_data=0, overflow=0.
  - Transmitter is not reset by this block; after reset mid-frame, FIFO contents are lost.
- FIFO:
  - Write accepted when wr_en && !fifo_full.
  - Write with fifo_full is dropped and sets overflow, even if a pop occurs the same cycle.
  - Simultaneous accepted write and pop: count unchanged.
  - Pointers wrap modulo DEPTH.
  - clear_overflow and a new overflow event in the same cycle: overflow stays 1.
- FSM states: IDLE, LOAD, SETTLE, HOLD, DRAIN.
- IDLE:
  - busy=0.
  - start && !fifo_empty -> LOAD; head word registered into tx_data, popped.
  - start while empty is ignored.
- LOAD:
  - tx_load=1 for exactly this cycle; tx_data stable -> SETTLE.
  - Latency: start sampled at cycle N, tx_load high at N+1.
- SETTLE:
  - tx_load=0; one cycle, to allow tx_full to reflect the load -> HOLD.
- HOLD:
  - tx_load=0.
  - !tx_full && !fifo_empty -> LOAD (pop next word into tx_data).
  - fifo_empty -> DRAIN.
  - Otherwise stay.
- DRAIN:
  - Ignores FIFO and start.
  - Waits for tx_active to be seen high, then low -> IDLE.
  - Words written during DRAIN remain queued for the next start.
- busy=1 in every state except IDLE.
- tx_load is low for at least 2 cycles between pulses, so every load is a distinct rising edge.
- tx_data changes only on entry to LOAD; it holds its value in all other states.
- Words written during HOLD join the current frame if they arrive before HOLD sees fifo_empty.
- Continuation loads occur only when tx_full is low. That is, within two cycles after the transmitter takes the previous word at its sync bit, which is well before that word's parity bit, so the frame chains.

Test Plan:
- Single word: write 0x2A5, pulse start -> one tx_load pulse with tx_data=0x2A5 at start+1; busy high until tx_active falls; fifo_empty=1 throughout DRAIN.
- Three-word chain: write 0x001, 0x3FF, 0x155, start.
  - Three tx_load pulses in order with those data values, each issued only while tx_full=0.
  - tx_active stays high continuously across all three words; exactly one frame.
- Full/overflow with DEPTH=4: write 5 words -> fifo_full after 4, fifo_count=4, overflow=1; 5th word absent from output; clear_overflow -> overflow=0.
- Simultaneous write/pop: write lands on the same cycle as a HOLD->LOAD pop -> fifo_count unchanged; word order preserved.
- start with empty FIFO -> stays IDLE, busy=0, no tx_load. Late write during DRAIN -> not loaded until the next start.
- Assert reset_n=0 mid-HOLD with 3 words queued -> immediately busy=0, tx_load=0, fifo_count=0, overflow=0.
